// File: rtl/poly_mul_pkg.sv
// Shared types for the polynomial-multiplier sequencer: FSM states,
// the strobe bundle driven toward the CSR/MAC datapath, and op length.
package poly_mul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROW,
        MAC,
        DONE
    } state_e;

    // Field order is shared with anything that packs/unpacks the strobes.
    typedef struct packed {
        logic csr1_load;
        logic csr1_en;
        logic csr2_load;
        logic csr2_en;
        logic mac_en;
        logic acc_clr;
    } strobe_t;

    // Cycle offset from the start-sampling cycle to the first DONE cycle.
    function automatic int op_cycles(input int n);
        return n * (n + 1) + 2;
    endfunction

endpackage

// File: rtl/poly_mod_counter.sv
// Modulo-MOD up counter with synchronous clear; wrap flags the last
// enabled count so the caller can chain counters.
module poly_mod_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q, count_d;

    // Wrap is explicit at MOD-1 so non-power-of-two MOD never reaches 2^W-1.
    assign wrap  = en && (count_q == W'(MOD - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = wrap ? '0 : count_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/poly_mul_sequencer.sv
// Sequencer for the CSR-based polynomial multiplier: load A, then per B
// row load CSR2 and run N MAC cycles, finally hold the result for handshake.
module poly_mul_sequencer
    import poly_mul_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          out_ready,
    output logic          csr1_load,
    output logic          csr1_en,
    output logic          csr2_load,
    output logic          csr2_en,
    output logic          mac_en,
    output logic          acc_clr,
    output logic          busy,
    output logic          out_valid,
    output logic [CW-1:0] row_idx,
    output logic [CW-1:0] col_idx
);

    state_e  state_q, state_d;
    strobe_t st;
    logic    cnt_clr;
    logic    col_en, col_wrap;
    logic    row_wrap;
    logic    in_op;

    assign in_op   = (state_q == LOAD) || (state_q == ROW) || (state_q == MAC);
    assign cnt_clr = (state_q == IDLE) || (abort && in_op);
    assign col_en  = (state_q == MAC);

    poly_mod_counter #(.MOD(N), .W(CW)) u_col (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (col_en),
        .count (col_idx),
        .wrap  (col_wrap)
    );

    // Row advances once per completed MAC sweep; its wrap marks the last row.
    poly_mod_counter #(.MOD(N), .W(CW)) u_row (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (col_wrap),
        .count (row_idx),
        .wrap  (row_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        st      = '0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = LOAD;
            end
            LOAD: begin
                st.csr1_load = 1'b1;
                st.acc_clr   = 1'b1;
                state_d      = abort ? IDLE : ROW;
            end
            ROW: begin
                st.csr2_load = 1'b1;
                state_d      = abort ? IDLE : MAC;
            end
            MAC: begin
                st.csr2_en = 1'b1;
                st.mac_en  = 1'b1;
                st.csr1_en = col_wrap;
                if (abort)
                    state_d = IDLE;
                else if (col_wrap)
                    state_d = row_wrap ? DONE : ROW;
            end
            DONE: begin
                // A dropped result is just an early handshake.
                if (out_ready || abort)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign csr1_load = st.csr1_load;
    assign csr1_en   = st.csr1_en;
    assign csr2_load = st.csr2_load;
    assign csr2_en   = st.csr2_en;
    assign mac_en    = st.mac_en;
    assign acc_clr   = st.acc_clr;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);

endmodule
